// File: rtl/font_glyph_engine.sv
// Glyph-to-pixel engine: writable font RAM, row lookup, column select and
// invert/underline/blink attributes, delivered as a 2-stage pixel pipeline.
module font_glyph_engine #(
    parameter int unsigned CHAR_W        = 8,
    parameter int unsigned CHAR_H        = 16,
    parameter int unsigned NUM_CHARS     = 128,
    parameter int unsigned CODE_W        = 7,
    parameter int unsigned ROW_W         = 4,
    parameter int unsigned COL_W         = 3,
    parameter int unsigned UNDERLINE_ROW = 14,
    parameter int unsigned BLINK_FRAMES  = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CODE_W-1:0] wr_code,
    input  logic [ROW_W-1:0]  wr_row,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic              frame_tick,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    input  logic [ROW_W-1:0]  in_row,
    input  logic [COL_W-1:0]  in_col,
    input  logic [2:0]        in_attr,
    output logic              out_valid,
    output logic              out_pixel,
    output logic              blink_phase
);

    localparam int unsigned DEPTH  = NUM_CHARS * CHAR_H;
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CHAR_W-1:0] mem_q [DEPTH] = '{default: '0};

    logic              wr_ok;
    logic              rd_oor;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              phase_q, phase_d;

    logic              v1_q;
    logic [CHAR_W-1:0] word1_q;
    logic [COL_W-1:0]  col1_q;
    logic [2:0]        attr1_q;
    logic              oor1_q;
    logic              ulrow1_q;
    logic              phase1_q;

    logic              glyph_bit;
    logic              ul_bit;
    logic              pix_d;
    logic              out_valid_q;
    logic              out_pixel_q;

    // Linear address is code*CHAR_H + row so non-power-of-2 heights pack densely.
    always_comb begin
        wr_ok   = wr_en && (32'(wr_code) < NUM_CHARS) && (32'(wr_row) < CHAR_H);
        rd_oor  = (32'(in_code) >= NUM_CHARS) || (32'(in_row) >= CHAR_H) ||
                  (32'(in_col) >= CHAR_W);
        wr_addr = ADDR_W'(32'(wr_code) * CHAR_H + 32'(wr_row));
        rd_addr = rd_oor ? '0 : ADDR_W'(32'(in_code) * CHAR_H + 32'(in_row));
    end

    // Font RAM is never reset; the read sees the pre-write word on a collision.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
        word1_q <= mem_q[rd_addr];
    end

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (frame_tick) begin
            if (32'(cnt_q) == BLINK_FRAMES - 1) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            phase_q     <= 1'b0;
            v1_q        <= 1'b0;
            col1_q      <= '0;
            attr1_q     <= '0;
            oor1_q      <= 1'b0;
            ulrow1_q    <= 1'b0;
            phase1_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_pixel_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            v1_q        <= in_valid;
            col1_q      <= in_col;
            attr1_q     <= in_attr;
            oor1_q      <= rd_oor;
            ulrow1_q    <= (32'(in_row) == UNDERLINE_ROW);
            phase1_q    <= phase_q;
            out_valid_q <= v1_q;
            out_pixel_q <= pix_d;
        end
    end

    // Column 0 is the MSB of the stored row.
    always_comb begin
        glyph_bit = 1'b0;
        for (int unsigned i = 0; i < CHAR_W; i++) begin
            if (32'(col1_q) == i) begin
                glyph_bit = word1_q[CHAR_W-1-i];
            end
        end
        glyph_bit = glyph_bit & ~oor1_q;
        ul_bit    = attr1_q[1] & ulrow1_q;
        pix_d     = v1_q & (((glyph_bit | ul_bit) & ~(attr1_q[2] & phase1_q)) ^ attr1_q[0]);
    end

    assign out_valid   = out_valid_q;
    assign out_pixel   = out_pixel_q;
    assign blink_phase = phase_q;

endmodule

// File: tb/tb_font_glyph_engine.sv
// Directed bench for font_glyph_engine with CODE_W=8 and BLINK_FRAMES=3.
module tb_font_glyph_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_code;
    logic [3:0] wr_row;
    logic [7:0] wr_data;
    logic       frame_tick;
    logic       in_valid;
    logic [7:0] in_code;
    logic [3:0] in_row;
    logic [2:0] in_col;
    logic [2:0] in_attr;
    logic       out_valid;
    logic       out_pixel;
    logic       blink_phase;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    font_glyph_engine #(
        .CHAR_W       (8),
        .CHAR_H       (16),
        .NUM_CHARS    (128),
        .CODE_W       (8),
        .ROW_W        (4),
        .COL_W        (3),
        .UNDERLINE_ROW(14),
        .BLINK_FRAMES (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_code    (wr_code),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .frame_tick (frame_tick),
        .in_valid   (in_valid),
        .in_code    (in_code),
        .in_row     (in_row),
        .in_col     (in_col),
        .in_attr    (in_attr),
        .out_valid  (out_valid),
        .out_pixel  (out_pixel),
        .blink_phase(blink_phase)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] c, input logic [3:0] r, input logic [7:0] d);
        wr_en = 1'b1; wr_code = c; wr_row = r; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic ftick();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
    endtask

    task automatic look(input string tag, input logic [7:0] c, input logic [3:0] r,
                        input logic [2:0] col, input logic [2:0] attr, input logic exp);
        in_valid = 1'b1; in_code = c; in_row = r; in_col = col; in_attr = attr;
        tick();
        in_valid = 1'b0;
        tick();
        chk({tag, " valid"}, out_valid, 1'b1);
        chk(tag, out_pixel, exp);
    endtask

    logic [7:0] a_rows [8] = '{8'h18, 8'h24, 8'h42, 8'h42, 8'h7E, 8'h42, 8'h42, 8'h42};
    logic [7:0] pat;

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_code = '0; wr_row = '0; wr_data = '0;
        frame_tick = 1'b0; in_valid = 1'b0; in_code = '0; in_row = '0;
        in_col = '0; in_attr = '0;
        tick();
        tick();
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset out_pixel", out_pixel, 1'b0);
        chk("reset blink_phase", blink_phase, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) wr(8'd65, 4'(3 + i), a_rows[i]);
        look("A r3c3", 8'd65, 4'd3, 3'd3, 3'b000, 1'b1);
        look("A r3c0", 8'd65, 4'd3, 3'd0, 3'b000, 1'b0);
        look("A r7c1", 8'd65, 4'd7, 3'd1, 3'b000, 1'b1);
        look("A r7c7", 8'd65, 4'd7, 3'd7, 3'b000, 1'b0);

        pat = 8'b0001_1000;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                in_valid = 1'b1; in_code = 8'd65; in_row = 4'd3;
                in_col = 3'(i); in_attr = 3'b000;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (i > 0) begin
                chk("stream valid", out_valid, 1'b1);
                chk("stream pixel", out_pixel, pat[8 - i]);
            end
        end
        tick();
        chk("idle valid", out_valid, 1'b0);
        chk("idle pixel", out_pixel, 1'b0);

        wr_en = 1'b1; wr_code = 8'd1; wr_row = 4'd0; wr_data = 8'hFF;
        in_valid = 1'b1; in_code = 8'd1; in_row = 4'd0; in_col = 3'd0; in_attr = 3'b000;
        tick();
        wr_en = 1'b0;
        tick();
        chk("rfw old valid", out_valid, 1'b1);
        chk("rfw old pixel", out_pixel, 1'b0);
        in_valid = 1'b0;
        tick();
        chk("rfw new pixel", out_pixel, 1'b1);

        look("plain r14", 8'd0, 4'd14, 3'd0, 3'b000, 1'b0);
        look("ul r14", 8'd0, 4'd14, 3'd0, 3'b010, 1'b1);
        look("ul inv r14", 8'd0, 4'd14, 3'd0, 3'b011, 1'b0);
        look("ul r13", 8'd0, 4'd13, 3'd0, 3'b010, 1'b0);

        look("oor code", 8'd200, 4'd3, 3'd3, 3'b000, 1'b0);
        look("oor inv", 8'd200, 4'd3, 3'd3, 3'b001, 1'b1);
        look("oor ul", 8'd200, 4'd14, 3'd0, 3'b010, 1'b1);
        wr(8'd200, 4'd0, 8'hFF);
        look("oor write alias 72", 8'd72, 4'd0, 3'd0, 3'b000, 1'b0);
        look("oor after write", 8'd200, 4'd0, 3'd0, 3'b000, 1'b0);

        ftick(); chk("phase tick1", blink_phase, 1'b0);
        ftick(); chk("phase tick2", blink_phase, 1'b0);
        ftick(); chk("phase tick3", blink_phase, 1'b1);
        look("blink lit off", 8'd65, 4'd3, 3'd3, 3'b100, 1'b0);
        look("noblink lit", 8'd65, 4'd3, 3'd3, 3'b000, 1'b1);
        look("blink inv", 8'd65, 4'd3, 3'd3, 3'b101, 1'b1);
        ftick(); ftick(); chk("phase tick5", blink_phase, 1'b1);
        ftick(); chk("phase tick6", blink_phase, 1'b0);
        look("blink lit on", 8'd65, 4'd3, 3'd3, 3'b100, 1'b1);

        ftick(); ftick();
        frame_tick = 1'b1;
        in_valid = 1'b1; in_code = 8'd65; in_row = 4'd3; in_col = 3'd3; in_attr = 3'b100;
        tick();
        frame_tick = 1'b0; in_valid = 1'b0;
        chk("coincident phase", blink_phase, 1'b1);
        tick();
        chk("coincident old phase", out_pixel, 1'b1);

        in_valid = 1'b1; in_code = 8'd65; in_row = 4'd3; in_col = 3'd3; in_attr = 3'b000;
        tick();
        tick();
        chk("prerst valid", out_valid, 1'b1);
        chk("prerst pixel", out_pixel, 1'b1);
        rst = 1'b1;
        wr_en = 1'b1; wr_code = 8'd2; wr_row = 4'd5; wr_data = 8'h80;
        tick();
        rst = 1'b0; wr_en = 1'b0;
        chk("rst slot1 valid", out_valid, 1'b0);
        chk("rst slot1 pixel", out_pixel, 1'b0);
        chk("rst phase", blink_phase, 1'b0);
        tick();
        chk("rst slot2 valid", out_valid, 1'b0);
        tick();
        chk("resume valid", out_valid, 1'b1);
        chk("resume pixel", out_pixel, 1'b1);
        in_valid = 1'b0;
        tick();
        tick();

        ftick(); ftick(); chk("rst cnt tick2", blink_phase, 1'b0);
        ftick(); chk("rst cnt tick3", blink_phase, 1'b1);

        look("keep A r3c4", 8'd65, 4'd3, 3'd4, 3'b000, 1'b1);
        look("keep code1", 8'd1, 4'd0, 3'd7, 3'b000, 1'b1);
        look("write in rst c0", 8'd2, 4'd5, 3'd0, 3'b000, 1'b1);
        look("write in rst c1", 8'd2, 4'd5, 3'd1, 3'b000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/font_glyph_engine.md
Name: font_glyph_engine

Overview:
Parametrised glyph-to-pixel engine for the VGA text path. It holds a run-time writable font memory, looks up glyph rows, selects the addressed column bit, and applies per-character attributes: invert, underline and blink. Output is a 2-cycle pipelined pixel stream with valid. Blink phase comes from an internal frame counter.

Parameters:
CHAR_W, 8, glyph width in pixels; one memory word per glyph row.
CHAR_H, 16, glyph height in rows.
NUM_CHARS, 128, number of glyph codes stored.
CODE_W, 7, width of character code inputs.
ROW_W, 4, width of row index inputs.
COL_W, 3, width of column index input.
UNDERLINE_ROW, 14, glyph row drawn solid when underline is set.
BLINK_FRAMES, 30, frame ticks per blink half-period (>=1).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
wr_en  in  1  glyph memory write strobe
wr_code  in  CODE_W  code of glyph being written
wr_row  in  ROW_W  row of glyph being written
wr_data  in  CHAR_W  row bitmap; MSB = leftmost pixel
frame_tick  in  1  one-cycle pulse per video frame
in_valid  in  1  lookup request valid
in_code  in  CODE_W  character code
in_row  in  ROW_W  pixel row within glyph
in_col  in  COL_W  pixel column within glyph; 0 = leftmost
in_attr  in  3  {blink, underline, invert}
out_valid  out  1  pixel valid
out_pixel  out  1  final foreground bit
blink_phase  out  1  current blink phase; 1 = blinked-off

Behaviour:
- Memory depth is NUM_CHARS*CHAR_H words of CHAR_W bits. Address = code*CHAR_H + row; this is a multiply, not a concatenation, so non-power-of-2 CHAR_H works.
- Memory contents are all-zero at configuration. rst does not clear memory.
- Write: when wr_en=1, code<NUM_CHARS and row<CHAR_H, the word is written on that clk edge. Out-of-range writes are ignored.
- Read is synchronous and read-first. A write and a read to the same address in the same cycle return the old data. The new data is visible to lookups accepted on the next cycle.
- Pipeline has no backpressure. A lookup is accepted every cycle in_valid=1.
- S1 (edge after accept): memory read registered. col, attr, range flag, and blink phase (sampled at accept) pipelined.
- S2 (next edge): out_valid and out_pixel registered. Latency is exactly 2 cycles, in_valid to out_valid.
- Range flag: code>=NUM_CHARS, row>=CHAR_H or col>=CHAR_W forces the glyph bit to 0. Underline and invert still apply.
- glyph_bit = word[CHAR_W-1-col].
- ul = underline && row==UNDERLINE_ROW.
- out_pixel = ((glyph_bit | ul) & ~(blink & phase)) ^ invert.
- out_pixel is forced to 0 whenever out_valid=0.
- Blink counter: 0..BLINK_FRAMES-1. On each frame_tick it increments. On a tick at BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
- A frame_tick coincident with an accepted lookup: the lookup uses the old phase.
- Reset values: out_valid=0, out_pixel=0, blink_phase=0, blink counter=0. All pipeline valid bits are cleared.
- rst asserted mid-stream: in-flight lookups are discarded, out_valid=0 on the next cycle. Lookups presented while rst=1 are dropped.
- A write with wr_en=1 while rst=1 still completes.

Test Plan:
- Write code 65 rows 3..10 with the 'A' bitmap (row3=0x18). Look up code 65, row 3, col 3 at cycle t -> out_valid=1 and out_pixel=1 at t+2. col 0 -> 0. Back-to-back lookups for cols 0..7 stream 0,0,0,1,1,0,0,0.
- Same-cycle write 0xFF and read of code 1 row 0 (old 0x00) -> pixel 0. Repeat read next cycle -> pixel 1.
- Code 0 row 14 col 0 (glyph 0): underline=1 -> 1. Add invert -> 0. Row 13 with underline only -> 0.
- Code 200 with CODE_W=8, NUM_CHARS=128 -> pixel 0. Same with invert -> 1. Write to code 200 -> memory unchanged.
- BLINK_FRAMES=3: ticks 1,2 -> phase 0; tick 3 -> phase 1; tick 6 -> 0. Blink-attributed lit pixel outputs 0 only while phase=1. Non-blink pixel is unaffected.
- Stream in_valid=1, assert rst for 1 cycle -> out_valid=0 for the next 2 output slots. blink_phase and counter are 0. Previously written glyphs still read back intact.
